// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle-strobe memory port between two requesters.
// Requests are taken one at a time (IDLE -> ISSUE -> WAIT -> RESP -> IDLE).
// Each transaction drives the memory strobes for one cycle, waits MEM_LATENCY
// cycles, then returns a one-cycle response to the granted port.
// Optional feature macro ARB_ROUND_ROBIN_EN: when defined, simultaneous
// requests alternate between the ports via last_grant. When it is undefined,
// port 0 always wins ties.
module mem_arbiter #(
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_valid,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [3:0]  p0_wmask,
   output logic        p0_ready,
   output logic        p0_resp,
   input  logic        p1_valid,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [3:0]  p1_wmask,
   output logic        p1_ready,
   output logic        p1_resp,
   output logic [31:0] p_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   output logic        mem_rstrb,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [MASK_W-1:0]  lat_wmask;
   logic               grant;
`ifdef ARB_ROUND_ROBIN_EN
   logic               last_grant;
`endif

   logic               sel_c;
   logic [ADDR_W-1:0]  sel_addr_c;
   logic [DATA_W-1:0]  sel_wdata_c;
   logic [MASK_W-1:0]  sel_wmask_c;

   // Winner selection among the pending requests (only used in IDLE)
   always_comb begin
      sel_c = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      if (p0_valid && p1_valid) begin
         sel_c = ~last_grant;
      end else begin
         sel_c = ~p0_valid;
      end
`else
      sel_c = ~p0_valid;
`endif
      sel_addr_c  = sel_c ? p1_addr  : p0_addr;
      sel_wdata_c = sel_c ? p1_wdata : p0_wdata;
      sel_wmask_c = sel_c ? p1_wmask : p0_wmask;
   end

   // Transaction sequencer with registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_wmask <= '0;
         grant     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant <= 1'b1;
`endif
         p0_ready  <= 1'b0;
         p1_ready  <= 1'b0;
         p0_resp   <= 1'b0;
         p1_resp   <= 1'b0;
         p_rdata   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         mem_rstrb <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (p0_valid || p1_valid) begin
                  state     <= ISSUE;
                  grant     <= sel_c;
`ifdef ARB_ROUND_ROBIN_EN
                  last_grant <= sel_c;
`endif
                  // mem_addr/mem_wdata double as the request latch
                  mem_addr  <= sel_addr_c;
                  mem_wdata <= sel_wdata_c;
                  mem_wmask <= sel_wmask_c;
                  lat_wmask <= sel_wmask_c;
                  mem_rstrb <= (sel_wmask_c == MASK_W'(0));
                  p0_ready  <= ~sel_c;
                  p1_ready  <= sel_c;
                  busy      <= 1'b1;
               end
            end
            ISSUE: begin
               mem_wmask <= '0;
               mem_rstrb <= 1'b0;
               p0_ready  <= 1'b0;
               p1_ready  <= 1'b0;
               cnt       <= CNT_W'(MEM_LATENCY);
               state     <= WAIT;
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  p_rdata <= (lat_wmask == MASK_W'(0)) ? mem_rdata : '0;
                  p0_resp <= ~grant;
                  p1_resp <= grant;
                  state   <= RESP;
               end
            end
            RESP: begin
               p0_resp <= 1'b0;
               p1_resp <= 1'b0;
               p_rdata <= '0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions on a
// MEM_LATENCY=1 instance, plus hand sequences for reset-in-WAIT, request
// during busy and a MEM_LATENCY=4 instance.
module tb_mem_arbiter;

   localparam int unsigned LAT  = 1;
   localparam int unsigned LAT4 = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ram_load;

   // instance A (MEM_LATENCY = 1)
   logic        p0_valid, p1_valid;
   logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic [3:0]  p0_wmask, p1_wmask;
   logic        p0_ready, p1_ready, p0_resp, p1_resp;
   logic [31:0] p_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb, busy;

   // instance B (MEM_LATENCY = 4)
   logic        p0_valid_b, p1_valid_b;
   logic [31:0] p0_addr_b, p1_addr_b, p0_wdata_b, p1_wdata_b;
   logic [3:0]  p0_wmask_b, p1_wmask_b;
   logic        p0_ready_b, p1_ready_b, p0_resp_b, p1_resp_b;
   logic [31:0] p_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
   logic [3:0]  mem_wmask_b;
   logic        mem_rstrb_b, busy_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
      .p0_ready(p0_ready), .p0_resp(p0_resp),
      .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
      .p1_ready(p1_ready), .p1_resp(p1_resp),
      .p_rdata(p_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.MEM_LATENCY(LAT4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .p0_valid(p0_valid_b), .p0_addr(p0_addr_b), .p0_wdata(p0_wdata_b), .p0_wmask(p0_wmask_b),
      .p0_ready(p0_ready_b), .p0_resp(p0_resp_b),
      .p1_valid(p1_valid_b), .p1_addr(p1_addr_b), .p1_wdata(p1_wdata_b), .p1_wmask(p1_wmask_b),
      .p1_ready(p1_ready_b), .p1_resp(p1_resp_b),
      .p_rdata(p_rdata_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_wmask(mem_wmask_b), .mem_rstrb(mem_rstrb_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
   );

   // RAM model for instance A: data appears only on the cycle the latency expires
   logic [31:0] ram [0:15];
   logic [3:0]  raddr;
   int          mcnt;
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
         ram[4] <= 32'hDEAD_BEEF;
         ram[5] <= 32'h5566_7788;
         ram[8] <= 32'h1122_3344;
      end else begin
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (!rst_n) begin
         mcnt  <= 0;
         raddr <= 4'h0;
      end else if (mem_rstrb) begin
         mcnt  <= LAT;
         raddr <= mem_addr[5:2];
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
      end
   end
   assign mem_rdata = (mcnt == 1) ? ram[raddr] : 32'hBADB_AD00;

   // Memory model for instance B: correct word only in the last latency cycle
   int mcnt4;
   always @(posedge clk) begin
      if (!rst_n) mcnt4 <= 0;
      else if (mem_rstrb_b) mcnt4 <= LAT4;
      else if (mcnt4 != 0) mcnt4 <= mcnt4 - 1;
   end
   assign mem_rdata_b = (mcnt4 == 1) ? 32'hCAFE_F00D : 32'h0BAD_0BAD;

   typedef struct {
      logic        rst;
      logic        p0v;
      logic [31:0] p0a;
      logic [3:0]  p0m;
      logic [31:0] p0d;
      logic        p1v;
      logic [31:0] p1a;
      logic [3:0]  p1m;
      logic [31:0] p1d;
      logic        exp_port;
      logic [31:0] exp_rdata;
   } vec_t;

   function automatic vec_t mk(input logic rst,
                               input logic p0v, input logic [31:0] p0a, input logic [3:0] p0m,
                               input logic [31:0] p0d,
                               input logic p1v, input logic [31:0] p1a, input logic [3:0] p1m,
                               input logic [31:0] p1d,
                               input logic exp_port, input logic [31:0] exp_rdata);
      vec_t v;
      v.rst = rst; v.p0v = p0v; v.p0a = p0a; v.p0m = p0m; v.p0d = p0d;
      v.p1v = p1v; v.p1a = p1a; v.p1m = p1m; v.p1d = p1d;
      v.exp_port = exp_port; v.exp_rdata = exp_rdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One transaction on instance A, timed from the cycle the request is presented
   task automatic do_txn(input vec_t v, input int idx);
      int          n, rdy_n, resp_n, busy_n, strb_n, wm_n;
      logic        rdy_port, resp_port;
      logic [31:0] rd, a_seen, exp_a;
      logic [3:0]  wm_seen, exp_m;
      if (v.rst) begin
         rst_n = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
      end
      p0_valid = v.p0v; p0_addr = v.p0a; p0_wmask = v.p0m; p0_wdata = v.p0d;
      p1_valid = v.p1v; p1_addr = v.p1a; p1_wmask = v.p1m; p1_wdata = v.p1d;
      exp_m = v.exp_port ? v.p1m : v.p0m;
      exp_a = v.exp_port ? v.p1a : v.p0a;
      n = 0; rdy_n = 0; resp_n = 0; busy_n = 0; strb_n = 0; wm_n = 0;
      rdy_port = 1'b0; resp_port = 1'b0; rd = 32'h0; a_seen = 32'h0; wm_seen = 4'h0;
      while (resp_n == 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (busy) busy_n++;
         if (mem_rstrb) strb_n++;
         if (mem_wmask != 4'h0) begin wm_n++; wm_seen = mem_wmask; end
         if (mem_rstrb || mem_wmask != 4'h0) a_seen = mem_addr;
         if (p0_ready || p1_ready) begin
            rdy_n = n; rdy_port = p1_ready;
            if (p0_ready) p0_valid = 1'b0;
            if (p1_ready) p1_valid = 1'b0;
         end
         if (p0_resp || p1_resp) begin resp_n = n; resp_port = p1_resp; rd = p_rdata; end
      end
      chk($sformatf("vec%0d resp_cycle", idx), 32'(resp_n), 32'(LAT + 2));
      chk($sformatf("vec%0d ready_cycle", idx), 32'(rdy_n), 32'd1);
      chk($sformatf("vec%0d ready_port", idx), 32'(rdy_port), 32'(v.exp_port));
      chk($sformatf("vec%0d resp_port", idx), 32'(resp_port), 32'(v.exp_port));
      chk($sformatf("vec%0d rdata", idx), rd, v.exp_rdata);
      chk($sformatf("vec%0d rstrb_cycles", idx), 32'(strb_n), (exp_m == 4'h0) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d wmask_cycles", idx), 32'(wm_n), (exp_m != 4'h0) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d wmask", idx), 32'(wm_seen), 32'(exp_m));
      chk($sformatf("vec%0d mem_addr", idx), a_seen, exp_a);
      chk($sformatf("vec%0d busy_cycles", idx), 32'(busy_n), 32'(LAT + 2));
      @(posedge clk); #1;
      chk($sformatf("vec%0d idle_after", idx), 32'({busy, p0_resp, p1_resp}), 32'd0);
   endtask

   vec_t vecs[12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          r0, r1, rr1, strb_map, busy_n, rdy_n, resp_n, strb_n;
      logic [31:0] rd;

      vecs[0]  = mk(0, 1, 32'h10, 4'h0, 32'h0,         0, 32'h0,  4'h0,    32'h0,        0, 32'hDEAD_BEEF);
      vecs[1]  = mk(0, 0, 32'h0,  4'h0, 32'h0,         1, 32'h20, 4'b0011, 32'h0000_ABCD, 1, 32'h0);
      vecs[2]  = mk(0, 0, 32'h0,  4'h0, 32'h0,         1, 32'h20, 4'h0,    32'h0,        1, 32'h1122_ABCD);
      vecs[3]  = mk(0, 1, 32'h14, 4'b1000, 32'hA500_0000, 0, 32'h0, 4'h0,  32'h0,        0, 32'h0);
      vecs[4]  = mk(0, 1, 32'h17, 4'h0, 32'h0,         0, 32'h0,  4'h0,    32'h0,        0, 32'hA566_7788);
      vecs[5]  = mk(1, 1, 32'h10, 4'h0, 32'h0,         1, 32'h20, 4'h0,    32'h0,        0, 32'hDEAD_BEEF);
`ifdef ARB_ROUND_ROBIN_EN
      vecs[6]  = mk(0, 1, 32'h10, 4'h0, 32'h0,         1, 32'h20, 4'h0,    32'h0,        1, 32'h1122_ABCD);
      vecs[7]  = mk(0, 1, 32'h10, 4'h0, 32'h0,         1, 32'h20, 4'h0,    32'h0,        0, 32'hDEAD_BEEF);
      vecs[8]  = mk(0, 1, 32'h10, 4'h0, 32'h0,         1, 32'h20, 4'h0,    32'h0,        1, 32'h1122_ABCD);
`else
      vecs[6]  = mk(0, 1, 32'h10, 4'h0, 32'h0,         1, 32'h20, 4'h0,    32'h0,        0, 32'hDEAD_BEEF);
      vecs[7]  = mk(0, 1, 32'h10, 4'h0, 32'h0,         1, 32'h20, 4'h0,    32'h0,        0, 32'hDEAD_BEEF);
      vecs[8]  = mk(0, 1, 32'h10, 4'h0, 32'h0,         1, 32'h20, 4'h0,    32'h0,        0, 32'hDEAD_BEEF);
`endif
      vecs[9]  = mk(0, 0, 32'h0,  4'h0, 32'h0,         1, 32'h20, 4'h0,    32'h0,        1, 32'h1122_ABCD);
      vecs[10] = mk(0, 1, 32'h10, 4'hF, 32'h1234_5678, 0, 32'h0,  4'h0,    32'h0,        0, 32'h0);
      vecs[11] = mk(0, 0, 32'h0,  4'h0, 32'h0,         1, 32'h10, 4'h0,    32'h0,        1, 32'h1234_5678);

      rst_n = 1'b0; ram_load = 1'b1;
      p0_valid = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_wmask = 4'h0;
      p1_valid = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_wmask = 4'h0;
      p0_valid_b = 1'b0; p0_addr_b = 32'h0; p0_wdata_b = 32'h0; p0_wmask_b = 4'h0;
      p1_valid_b = 1'b0; p1_addr_b = 32'h0; p1_wdata_b = 32'h0; p1_wmask_b = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      // reset state of both instances
      chk("rst ctrl", 32'({p0_ready, p1_ready, p0_resp, p1_resp, busy, mem_rstrb, mem_wmask}), 32'd0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst p_rdata", p_rdata, 32'h0);
      chk("rst4 ctrl", 32'({p0_ready_b, p1_ready_b, p0_resp_b, p1_resp_b, busy_b, mem_rstrb_b,
                            mem_wmask_b}), 32'd0);
      ram_load = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) do_txn(vecs[i], i);

      // request during busy: p1 rises while p0 is in WAIT
      p0_valid = 1'b1; p0_addr = 32'h14; p0_wmask = 4'h0;
      r0 = 0; r1 = 0; rr1 = 0; strb_map = 0; rd = 32'h0;
      for (int n = 1; n <= 9; n++) begin
         @(posedge clk); #1;
         if (mem_rstrb) strb_map |= (1 << n);
         if (p0_ready) p0_valid = 1'b0;
         if (p1_ready) begin p1_valid = 1'b0; if (r1 == 0) r1 = n; end
         if (p0_resp && r0 == 0) r0 = n;
         if (p1_resp && rr1 == 0) begin rr1 = n; rd = p_rdata; end
         if (n == 2) begin p1_valid = 1'b1; p1_addr = 32'h20; p1_wmask = 4'h0; end
      end
      chk("busy_req p0_resp_cycle", 32'(r0), 32'd3);
      chk("busy_req p1_ready_cycle", 32'(r1), 32'd5);
      chk("busy_req p1_resp_cycle", 32'(rr1), 32'd7);
      chk("busy_req strobe_map", 32'(strb_map), 32'h22);
      chk("busy_req p1_rdata", rd, 32'h1122_ABCD);

      // reset asserted while in WAIT
      p0_valid = 1'b1; p0_addr = 32'h10; p0_wmask = 4'h0;
      @(posedge clk); #1;
      chk("rst_wait ready", 32'(p0_ready), 32'd1);
      p0_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_wait busy_in_wait", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_wait ctrl", 32'({p0_ready, p1_ready, p0_resp, p1_resp, busy, mem_rstrb, mem_wmask}), 32'd0);
      chk("rst_wait mem_addr", mem_addr, 32'h0);
      chk("rst_wait p_rdata", p_rdata, 32'h0);
      rst_n = 1'b1;
      r0 = 0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (p0_resp || p1_resp || busy) r0++;
      end
      chk("rst_wait no_resp", 32'(r0), 32'd0);
      do_txn(mk(0, 1, 32'h10, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h1234_5678), 20);

      // MEM_LATENCY = 4 read on instance B
      p0_valid_b = 1'b1; p0_addr_b = 32'h40; p0_wmask_b = 4'h0;
      busy_n = 0; rdy_n = 0; resp_n = 0; strb_n = 0; rd = 32'h0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         if (busy_b) busy_n++;
         if (mem_rstrb_b) strb_n++;
         if (p0_ready_b) begin p0_valid_b = 1'b0; if (rdy_n == 0) rdy_n = n; end
         if (p0_resp_b && resp_n == 0) begin resp_n = n; rd = p_rdata_b; end
      end
      chk("lat4 ready_cycle", 32'(rdy_n), 32'd1);
      chk("lat4 resp_cycle", 32'(resp_n), 32'd6);
      chk("lat4 busy_cycles", 32'(busy_n), 32'd6);
      chk("lat4 rstrb_cycles", 32'(strb_n), 32'd1);
      chk("lat4 rdata", rd, 32'hCAFE_F00D);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single memory port (address, read strobe, byte write mask, read data) between two requesters: port 0 (processor) and port 1 (boot loader / debug DMA). It serialises requests one at a time, drives the memory strobes for exactly one cycle per transaction, waits a fixed memory read latency, and returns a one-cycle response to the granted requester. It sits between the processor/loader and the on-chip RAM.

## Interface
Parameters:
- MEM_LATENCY, 1, memory read latency in cycles from strobe edge to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- p0_valid / p1_valid  in  1  request pending; held until accepted
- p0_addr / p1_addr  in  32  byte address; word-aligned access, bits [1:0] passed through
- p0_wdata / p1_wdata  in  32  write data
- p0_wmask / p1_wmask  in  4  byte write enables; 4'b0000 = read
- p0_ready / p1_ready  out  1  accept pulse, one cycle
- p0_resp / p1_resp  out  1  response pulse, one cycle
- p_rdata  out  32  read data, valid while pN_resp is high (shared)
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wmask  out  4  memory byte write enables
- mem_rstrb  out  1  memory read strobe
- mem_rdata  in  32  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- Reset value of every output: 0; state IDLE; last_grant = 1 (port 0 preferred first).
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any pN_valid, select winner, latch its addr/wdata/wmask and grant id, go ISSUE. Else stay.
- Selection: only one valid -> that port. Both valid -> port != last_grant (round robin, see Configuration). last_grant updated on selection.
- ISSUE (1 cycle): mem_addr/mem_wdata/mem_wmask from latch; mem_rstrb = (wmask == 0); pN_ready = 1 for granted port; load counter with MEM_LATENCY; go WAIT.
- WAIT: decrement counter each cycle; on last cycle (counter == 1) capture mem_rdata into p_rdata register; go RESP.
- RESP (1 cycle): pN_resp = 1 for granted port; p_rdata holds captured word (reads) or 0 (writes). Go IDLE.
- mem_addr/mem_wdata hold latched value outside ISSUE; mem_wmask and mem_rstrb are 0 outside ISSUE.
- Requests arriving during a transaction wait; sampled only in IDLE.
- A requester dropping valid before ready: legal only in IDLE; request simply not seen.

## Timing
- Valid sampled at edge E0 in IDLE. ISSUE cycle E0-E1 (ready, strobe). WAIT cycles E1..E(1+MEM_LATENCY). RESP cycle follows.
- Request-to-response: MEM_LATENCY + 2 cycles from sampling edge to pN_resp high (3 cycles at MEM_LATENCY=1).
- Throughput: one transaction per MEM_LATENCY + 3 cycles; no pipelining, no back-to-back issue.
- Reset mid-transaction: state IDLE next edge, no resp issued, strobes drop immediately after edge; abandoned request must be re-presented.
- All outputs registered or decoded from registered state only; no combinational path from pN_valid to any output.

## Configuration
- ARB_ROUND_ROBIN_EN defined: tie-break on simultaneous requests alternates via last_grant.
- Not defined: fixed priority, port 0 always wins ties; last_grant register removed; port 1 served only when p0_valid low in IDLE.

## Test plan
- Single read, MEM_LATENCY=1: p0 read addr 0x0000_0010, RAM word 0xDEADBEEF -> p0_ready 1 cycle after sampling, mem_rstrb 1 cycle, p0_resp 3 cycles after sampling with p_rdata=0xDEADBEEF.
- Write: p1 wmask 4'b0011 addr 0x20 wdata 0x0000_ABCD -> mem_wmask=0011 for exactly 1 cycle, mem_rstrb=0, p1_resp with p_rdata=0.
- Contention with ARB_ROUND_ROBIN_EN: both valid continuously after reset -> grants 0,1,0,1; without macro -> grants 0,0,0,0.
- MEM_LATENCY=4: read -> p0_resp 6 cycles after sampling; rdata captured from 4th WAIT cycle; busy high for 6 cycles.
- Reset asserted in WAIT -> next cycle IDLE, all outputs 0, no pN_resp; re-presented request completes normally.
- Request during busy: p1_valid rises while p0 in WAIT -> p1 sampled in IDLE after p0 RESP, no overlap of strobes.
